// File: rtl/ring_counter_param.sv
// Parametrised one-hot ring / Johnson counter with enable, direction, load, position index and wrap pulse.
// Optional legal-state checking and recovery (with err output) enabled by defining RING_LEGAL_CHECK_EN.
module ring_counter_param #(
   parameter int  WIDTH    = 4,
   parameter int  INIT_POS = 0,
   localparam int PW       = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count_out,
   output logic [PW-1:0]    pos,
   output logic             wrap
`ifdef RING_LEGAL_CHECK_EN
   ,
   output logic             err
`endif
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic             wrap_q, wrap_d;
   logic             mode_q, mode_d;
   logic [PW-1:0]    pos_max;

   function automatic logic [WIDTH-1:0] reset_pat(input logic m);
      logic [WIDTH-1:0] p;
      p = '0;
      if (!m) p[INIT_POS] = 1'b1;
      return p;
   endfunction

   function automatic logic [PW-1:0] reset_pos(input logic m);
      return m ? '0 : PW'(INIT_POS);
   endfunction

   function automatic int popcount(input logic [WIDTH-1:0] v);
      int pc;
      pc = 0;
      for (int i = 0; i < WIDTH; i++) pc += int'(v[i]);
      return pc;
   endfunction

   // Lowest set bit doubles as the trailing-zero count; it is 0 when nothing is set.
   function automatic logic [PW-1:0] load_pos(input logic m, input logic [WIDTH-1:0] v);
      int   tz;
      logic found;
      tz    = 0;
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!found && v[i]) begin
            tz    = i;
            found = 1'b1;
         end
      end
      if (!m)              return PW'(tz);
      else if (v[WIDTH-1]) return PW'(WIDTH + tz);
      else                 return PW'(popcount(v));
   endfunction

`ifdef RING_LEGAL_CHECK_EN
   logic err_q, err_d;
   logic cur_legal, load_legal;

   // Johnson-legal means k low ones, or its complement (ones anchored at the top), k = 0..WIDTH.
   function automatic logic is_legal(input logic m, input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] lm;
      logic             ok;
      if (!m) return (popcount(v) == 1);
      lm = '0;
      ok = 1'b0;
      for (int k = 0; k <= WIDTH; k++) begin
         if (v == lm || v == ~lm) ok = 1'b1;
         if (k < WIDTH) lm[k] = 1'b1;
      end
      return ok;
   endfunction

   assign cur_legal  = is_legal(mode_q, count_q);
   assign load_legal = is_legal(mode_q, load_val);
   assign err        = err_q;
`endif

   assign pos_max = mode_q ? PW'(2 * WIDTH - 1) : PW'(WIDTH - 1);

   always_comb begin
      count_d = count_q;
      pos_d   = pos_q;
      wrap_d  = 1'b0;
      mode_d  = mode_q;
`ifdef RING_LEGAL_CHECK_EN
      err_d   = 1'b0;
`endif
      if (mode != mode_q) begin
         mode_d  = mode;
         count_d = reset_pat(mode);
         pos_d   = reset_pos(mode);
      end
`ifdef RING_LEGAL_CHECK_EN
      else if (!cur_legal) begin
         count_d = reset_pat(mode_q);
         pos_d   = reset_pos(mode_q);
         err_d   = 1'b1;
      end
      else if (load && !load_legal) begin
         err_d = 1'b1;
      end
`endif
      else if (load) begin
         count_d = load_val;
         pos_d   = load_pos(mode_q, load_val);
      end
      else if (en) begin
         if (!dir) begin
            count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1] ^ mode_q};
            wrap_d  = (pos_q == pos_max);
            pos_d   = wrap_d ? '0 : pos_q + PW'(1);
         end else begin
            count_d = {count_q[0] ^ mode_q, count_q[WIDTH-1:1]};
            wrap_d  = (pos_q == '0);
            pos_d   = wrap_d ? pos_max : pos_q - PW'(1);
         end
      end
   end

   // Reset samples the mode input so the reset pattern matches the selected sequence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= reset_pat(mode);
         pos_q   <= reset_pos(mode);
         wrap_q  <= 1'b0;
         mode_q  <= mode;
`ifdef RING_LEGAL_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         count_q <= count_d;
         pos_q   <= pos_d;
         wrap_q  <= wrap_d;
         mode_q  <= mode_d;
`ifdef RING_LEGAL_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign count_out = count_q;
   assign pos       = pos_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed, table-driven bench for ring_counter_param (WIDTH=4), plus a second instance with INIT_POS=2.
module tb_ring_counter_param;

   logic       clk, reset, en, dir, mode, load;
   logic [3:0] load_val;
   logic [3:0] count_out, count_out2;
   logic [2:0] pos, pos2;
   logic       wrap, wrap2;
`ifdef RING_LEGAL_CHECK_EN
   logic       err, err2;
`endif

   int checks = 0;
   int errors = 0;

   ring_counter_param #(.WIDTH(4), .INIT_POS(0)) dut (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .count_out(count_out), .pos(pos), .wrap(wrap)
`ifdef RING_LEGAL_CHECK_EN
      , .err(err)
`endif
   );

   ring_counter_param #(.WIDTH(4), .INIT_POS(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .count_out(count_out2), .pos(pos2), .wrap(wrap2)
`ifdef RING_LEGAL_CHECK_EN
      , .err(err2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       en, dir, mode, load;
      logic [3:0] lv;
      logic [3:0] ec;
      logic [2:0] ep;
      logic       ew;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic e, input logic d, input logic m, input logic l,
                      input logic [3:0] lv, input logic [3:0] ec, input logic [2:0] ep,
                      input logic ew);
      vec_t v;
      v.en = e; v.dir = d; v.mode = m; v.load = l;
      v.lv = lv; v.ec = ec; v.ep = ep; v.ew = ew;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic d, input logic m, input logic l,
                        input logic [3:0] lv);
      en = e; dir = d; mode = m; load = l; load_val = lv;
   endtask

   initial begin
      // ring, left
      add(1,0,0,0,4'h0, 4'b0010,1,0);
      add(1,0,0,0,4'h0, 4'b0100,2,0);
      add(1,0,0,0,4'h0, 4'b1000,3,0);
      add(1,0,0,0,4'h0, 4'b0001,0,1);
      add(0,0,0,0,4'h0, 4'b0001,0,0);
      // switch to Johnson, full left cycle, then reverse
      add(1,0,1,0,4'h0, 4'b0000,0,0);
      add(1,0,1,0,4'h0, 4'b0001,1,0);
      add(1,0,1,0,4'h0, 4'b0011,2,0);
      add(1,0,1,0,4'h0, 4'b0111,3,0);
      add(1,0,1,0,4'h0, 4'b1111,4,0);
      add(1,0,1,0,4'h0, 4'b1110,5,0);
      add(1,0,1,0,4'h0, 4'b1100,6,0);
      add(1,0,1,0,4'h0, 4'b1000,7,0);
      add(1,0,1,0,4'h0, 4'b0000,0,1);
      add(1,1,1,0,4'h0, 4'b1000,7,1);
      add(1,1,1,0,4'h0, 4'b1100,6,0);
      add(0,1,1,0,4'h0, 4'b1100,6,0);
      // back to ring with load asserted: mode change wins
      add(1,0,0,1,4'b1000, 4'b0001,0,0);
      add(1,0,0,0,4'h0,    4'b0010,1,0);
      add(1,0,0,1,4'b1000, 4'b1000,3,0);
      add(0,0,0,0,4'h0,    4'b1000,3,0);
      // ring, right, wrap 0->3, then turn around
      add(1,1,0,0,4'h0, 4'b0100,2,0);
      add(1,1,0,0,4'h0, 4'b0010,1,0);
      add(1,1,0,0,4'h0, 4'b0001,0,0);
      add(1,1,0,0,4'h0, 4'b1000,3,1);
      add(1,0,0,0,4'h0, 4'b0001,0,1);
      add(1,0,0,0,4'h0, 4'b0010,1,0);
      add(1,0,0,0,4'h0, 4'b0100,2,0);
      add(1,0,1,1,4'b1111, 4'b0000,0,0);
      // Johnson loads and pos derivation
      add(1,0,1,1,4'b1110, 4'b1110,5,0);
      add(0,0,1,1,4'b1111, 4'b1111,4,0);
      add(0,0,1,1,4'b1000, 4'b1000,7,0);
      add(1,1,1,1,4'b0000, 4'b0000,0,0);
      add(1,1,1,0,4'h0,    4'b1000,7,1);
      add(1,0,1,1,4'b0111, 4'b0111,3,0);

      drive(0,0,0,0,4'h0);
      reset = 1'b0;
      #12;
      check("reset count", {4'h0, count_out}, 8'h01);
      check("reset pos",   {5'h0, pos},       8'h00);
      check("reset wrap",  {7'h0, wrap},      8'h00);
      check("reset count init2", {4'h0, count_out2}, 8'h04);
      check("reset pos init2",   {5'h0, pos2},       8'h02);
      #3 reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].lv);
         @(posedge clk);
         #1;
         check($sformatf("v%0d count", i), {4'h0, count_out}, {4'h0, vecs[i].ec});
         check($sformatf("v%0d pos", i),   {5'h0, pos},       {5'h0, vecs[i].ep});
         check($sformatf("v%0d wrap", i),  {7'h0, wrap},      {7'h0, vecs[i].ew});
`ifdef RING_LEGAL_CHECK_EN
         check($sformatf("v%0d err", i),   {7'h0, err},       8'h00);
`endif
      end

      // Johnson at 0111, reset asserted between edges
      #3 reset = 1'b0;
      #1;
      check("async reset count", {4'h0, count_out}, 8'h00);
      check("async reset pos",   {5'h0, pos},       8'h00);
      check("async reset count init2", {4'h0, count_out2}, 8'h00);
      drive(0,0,0,0,4'h0);
      @(posedge clk);
      #1;
      check("reset ring count",       {4'h0, count_out},  8'h01);
      check("reset ring count init2", {4'h0, count_out2}, 8'h04);
      check("reset ring pos init2",   {5'h0, pos2},       8'h02);
      @(negedge clk);
      reset = 1'b1;

`ifdef RING_LEGAL_CHECK_EN
      drive(0,0,0,1,4'b0110);
      @(posedge clk); #1;
      check("illegal load count", {4'h0, count_out}, 8'h01);
      check("illegal load pos",   {5'h0, pos},       8'h00);
      check("illegal load err",   {7'h0, err},       8'h01);
      drive(0,0,0,0,4'h0);
      @(posedge clk); #1;
      check("err one cycle", {7'h0, err}, 8'h00);
      @(negedge clk);
      force dut.count_q = 4'b0011;
      #1 release dut.count_q;
      drive(1,0,0,1,4'b1000);
      @(posedge clk); #1;
      check("recover count", {4'h0, count_out}, 8'h01);
      check("recover pos",   {5'h0, pos},       8'h00);
      check("recover err",   {7'h0, err},       8'h01);
`else
      drive(0,0,0,1,4'b0110);
      @(posedge clk); #1;
      check("free load count", {4'h0, count_out}, 8'h06);
      check("free load pos",   {5'h0, pos},       8'h01);
      drive(1,0,0,0,4'h0);
      @(posedge clk); #1;
      check("free rotate count", {4'h0, count_out}, 8'h0c);
      check("free rotate pos",   {5'h0, pos},       8'h02);
      check("free rotate wrap",  {7'h0, wrap},      8'h00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
